// File: rtl/prog_delay_line_pkg.sv
// ----------------------------------------------------------------------------
// prog_delay_line_pkg
// Shared definitions for the programmable delay line: default sizes, the
// output-source selector and small arithmetic helpers used for depth
// clamping and circular-buffer address generation.
// No ports (package).
// ----------------------------------------------------------------------------
package prog_delay_line_pkg;

   localparam int unsigned DEF_WIDTH     = 10;
   localparam int unsigned DEF_MAX_DEPTH = 64;

   // Which register currently drives o_data: the RAM read register for real
   // delays, or the bypass register when the effective depth is zero.
   typedef enum logic {
      SRC_RAM    = 1'b0,
      SRC_BYPASS = 1'b1
   } out_src_e;

   // Saturate a requested depth to the largest supported depth.
   function automatic int unsigned clamp_depth(input int unsigned req,
                                               input int unsigned max_depth);
      return (req > max_depth) ? max_depth : req;
   endfunction

   // (ptr - d) mod modulus without relying on power-of-two wraparound.
   // Valid for ptr < modulus and d <= modulus; d == modulus returns ptr.
   function automatic int unsigned ptr_sub_mod(input int unsigned ptr,
                                               input int unsigned d,
                                               input int unsigned modulus);
      return (ptr >= d) ? (ptr - d) : (ptr + modulus - d);
   endfunction

endpackage

// File: rtl/prog_delay_line_sdp_ram_rbw.sv
// ----------------------------------------------------------------------------
// sdp_ram_rbw
// Simple dual-port RAM with one write port and one registered read port.
// A read and write to the same address in the same clock returns the OLD
// contents (read-before-write). r_data holds its value when r_en is low.
// Storage and the read register are not reset so the array maps onto
// block RAM.
// Ports:
//   clk     in   1      clock
//   w_en    in   1      write enable
//   w_addr  in   AW     write address
//   w_data  in   WIDTH  write data
//   r_en    in   1      read enable; loads r_data on the next edge
//   r_addr  in   AW     read address
//   r_data  out  WIDTH  registered read data
// ----------------------------------------------------------------------------
module sdp_ram_rbw #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             w_en,
   input  logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] w_data,
   input  logic             r_en,
   input  logic [AW-1:0]    r_addr,
   output logic [WIDTH-1:0] r_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (w_en)
         mem[w_addr] <= w_data;
   end

   // Read port. The non-blocking read samples the array before this edge's
   // write lands, which gives read-before-write on an address collision.
   always_ff @(posedge clk) begin
      if (r_en)
         r_data <= mem[r_addr];
   end

endmodule

// File: rtl/prog_delay_line.sv
// ----------------------------------------------------------------------------
// prog_delay_line
// Valid-gated delay line whose depth is programmable at runtime in
// 0..MAX_DEPTH beats. The pipeline advances only on accepted beats; each
// output is the sample accepted D beats earlier and appears one clock after
// the beat that retires it. Provides flush and a sticky depth-error flag.
// Ports:
//   clk          in   1      clock
//   reset        in   1      asynchronous, active-high
//   i_valid      in   1      input beat strobe
//   i_data       in   WIDTH  input sample
//   i_depth      in   DW     requested delay (clamped to MAX_DEPTH)
//   i_flush      in   1      discard all held samples
//   o_valid      out  1      high one clock after a retiring beat
//   o_data       out  WIDTH  delayed sample, holds between outputs
//   o_fill       out  DW     beats currently held, saturates at the depth
//   o_depth_err  out  1      sticky; set when i_depth exceeds MAX_DEPTH
// ----------------------------------------------------------------------------
module prog_delay_line
   import prog_delay_line_pkg::*;
#(
   parameter  int unsigned WIDTH     = DEF_WIDTH,
   parameter  int unsigned MAX_DEPTH = DEF_MAX_DEPTH,
   localparam int unsigned DW        = $clog2(MAX_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic [DW-1:0]    i_depth,
   input  logic             i_flush,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [DW-1:0]    o_fill,
   output logic             o_depth_err
);

   localparam int unsigned AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

   logic [DW-1:0]    d_eff;
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    fill;
   logic [DW-1:0]    fill_cur;
   logic [DW-1:0]    fill_next;
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    wptr_next;
   logic [AW-1:0]    rd_addr;
   logic             depth_change;
   logic             accept;
   logic             retire;
   logic             ram_rd;
   logic             bypass_rd;
   logic             depth_over;
   logic [WIDTH-1:0] bypass_q;
   logic [WIDTH-1:0] ram_rdata;
   out_src_e         out_src;
   logic             valid_q;
   logic             depth_err_q;

   // Effective depth and change detection. A new depth invalidates the
   // held history, so the fill seen by this cycle's beat is forced to zero;
   // that makes the concurrent beat become entry 1 of the new history.
   always_comb begin
      d_eff        = DW'(clamp_depth(32'(i_depth), MAX_DEPTH));
      depth_over   = (32'(i_depth) > MAX_DEPTH);
      depth_change = (d_eff != depth_q);
      fill_cur     = depth_change ? '0 : fill;
   end

   // Beat qualification. A beat retires when the history already holds
   // exactly D samples, so the oldest one leaves as this one enters.
   // Zero depth takes the bypass register instead of a RAM read.
   always_comb begin
      accept    = i_valid & ~i_flush;
      retire    = accept & (fill_cur == d_eff);
      ram_rd    = retire & (d_eff != '0);
      bypass_rd = retire & (d_eff == '0);
   end

   // Next-state for the write pointer and fill count. The pointer wraps at
   // MAX_DEPTH explicitly so non-power-of-two depths work.
   always_comb begin
      wptr_next = wptr;
      if (accept)
         wptr_next = (wptr == AW'(MAX_DEPTH - 1)) ? '0 : wptr + AW'(1);

      fill_next = fill_cur;
      if (i_flush)
         fill_next = '0;
      else if (accept)
         fill_next = (fill_cur < d_eff) ? fill_cur + DW'(1) : d_eff;

      rd_addr = AW'(ptr_sub_mod(32'(wptr), 32'(d_eff), MAX_DEPTH));
   end

   // Control state: pointer, fill, registered depth and the sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr        <= '0;
         fill        <= '0;
         depth_q     <= '0;
         depth_err_q <= 1'b0;
      end else begin
         wptr    <= wptr_next;
         fill    <= fill_next;
         depth_q <= d_eff;
         if (depth_over)
            depth_err_q <= 1'b1;
      end
   end

   // Output side: valid pipeline flop, bypass register and the selector
   // that remembers which register owns o_data. The selector only moves on
   // a retire, so o_data holds between outputs whichever source was last.
   // Resetting to the zeroed bypass register makes o_data read 0 without
   // resetting the RAM read register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q  <= 1'b0;
         bypass_q <= '0;
         out_src  <= SRC_BYPASS;
      end else begin
         valid_q <= retire;
         if (bypass_rd) begin
            bypass_q <= i_data;
            out_src  <= SRC_BYPASS;
         end else if (ram_rd) begin
            out_src  <= SRC_RAM;
         end
      end
   end

   sdp_ram_rbw #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk    (clk),
      .w_en   (accept),
      .w_addr (wptr),
      .w_data (i_data),
      .r_en   (ram_rd),
      .r_addr (rd_addr),
      .r_data (ram_rdata)
   );

   assign o_valid     = valid_q;
   assign o_data      = (out_src == SRC_BYPASS) ? bypass_q : ram_rdata;
   assign o_fill      = fill;
   assign o_depth_err = depth_err_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// ----------------------------------------------------------------------------
// tb_prog_delay_line
// Scoreboard bench for prog_delay_line (WIDTH=10, MAX_DEPTH=64). The driver
// pushes the expected sample and the cycle it must appear in; a monitor on
// the falling edge pops and compares whenever o_valid is high, and flags
// outputs that are missing or unexpected.
// ----------------------------------------------------------------------------
module tb_prog_delay_line;

   localparam int unsigned WIDTH     = 10;
   localparam int unsigned MAX_DEPTH = 64;
   localparam int unsigned DW        = $clog2(MAX_DEPTH + 1);

   logic             clk;
   logic             reset;
   logic             i_valid;
   logic [WIDTH-1:0] i_data;
   logic [DW-1:0]    i_depth;
   logic             i_flush;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic [DW-1:0]    o_fill;
   logic             o_depth_err;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc        = 0;
   int   vectors    = 0;
   int   miscompares = 0;

   prog_delay_line #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .i_depth     (i_depth),
      .i_flush     (i_flush),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_fill      (o_fill),
      .o_depth_err (o_depth_err)
   );

   // 10 ns clock and a free-running cycle index used to time outputs.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case anything stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // One clock of stimulus, driven just after the rising edge. When exp_en
   // is set the beat is expected to retire and exp_d must show on o_data at
   // the following falling edge.
   task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic f, input logic [DW-1:0] depth,
                                 input logic exp_en, input logic [WIDTH-1:0] exp_d);
      exp_t e;
      @(posedge clk);
      #1;
      i_valid = v;
      i_data  = d;
      i_flush = f;
      i_depth = depth;
      if (exp_en) begin
         e.data = exp_d;
         e.cyc  = cyc + 1;
         sb_q.push_back(e);
      end
   endtask

   task automatic idle(input int n, input logic [DW-1:0] depth);
      repeat (n) apply_stimulus(1'b0, '0, 1'b0, depth, 1'b0, '0);
   endtask

   task automatic drain(input string name, input logic [DW-1:0] depth);
      idle(4, depth);
      check_output(name, sb_q.size(), 0);
      sb_q.delete();
   endtask

   // Monitor: compare every presented output against the scoreboard head,
   // and treat an overdue head entry as a missing output.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (o_valid) begin
            if (sb_q.size() == 0) begin
               check_output("unexpected_valid", int'(o_data), -1);
            end else begin
               e = sb_q.pop_front();
               check_output("o_data", int'(o_data), int'(e.data));
               check_output("o_valid_cycle", cyc, e.cyc);
            end
         end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check_output("missing_valid", int'(o_valid), 1);
         end
      end
   end

   initial begin
      reset   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      i_depth = '0;
      i_flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_o_valid", int'(o_valid), 0);
      check_output("reset_o_data", int'(o_data), 0);
      check_output("reset_o_fill", int'(o_fill), 0);
      check_output("reset_o_depth_err", int'(o_depth_err), 0);
      #2 reset = 1'b0;

      // Bypass: depth 0, each beat comes straight back next clock.
      idle(2, 0);
      apply_stimulus(1'b1, 10'd1, 1'b0, 0, 1'b1, 10'd1);
      apply_stimulus(1'b1, 10'd2, 1'b0, 0, 1'b1, 10'd2);
      check_output("bypass_fill", int'(o_fill), 0);
      apply_stimulus(1'b1, 10'd3, 1'b0, 0, 1'b1, 10'd3);
      idle(1, 0);
      check_output("bypass_fill_end", int'(o_fill), 0);
      drain("bypass_drain", 0);

      // Depth 4 with idle cycles between beats.
      idle(2, 4);
      for (int k = 0; k < 10; k++) begin
         apply_stimulus(1'b1, 10'(k), 1'b0, 4, (k >= 4), 10'(k - 4));
         idle(1, 4);
      end
      check_output("gap_fill", int'(o_fill), 4);
      drain("gap_drain", 4);

      // Full depth across several pointer wraps.
      idle(2, 64);
      for (int k = 0; k < 200; k++)
         apply_stimulus(1'b1, 10'(k), 1'b0, 64, (k >= 64), 10'(k - 64));
      idle(1, 64);
      check_output("full_fill", int'(o_fill), 64);
      drain("full_drain", 64);

      // Depth 3, then depth 5 arriving together with beat 20.
      idle(2, 3);
      for (int k = 10; k < 20; k++)
         apply_stimulus(1'b1, 10'(k), 1'b0, 3, (k >= 13), 10'(k - 3));
      for (int k = 20; k < 30; k++) begin
         apply_stimulus(1'b1, 10'(k), 1'b0, 5, (k >= 25), 10'(k - 5));
         if (k >= 21 && k <= 25)
            check_output("depth_change_fill", int'(o_fill), k - 20);
      end
      drain("depth_change_drain", 5);

      // Flush with a concurrent beat at depth 2.
      idle(2, 2);
      apply_stimulus(1'b1, 10'd100, 1'b0, 2, 1'b0, '0);
      apply_stimulus(1'b1, 10'd101, 1'b0, 2, 1'b0, '0);
      apply_stimulus(1'b1, 10'd102, 1'b0, 2, 1'b1, 10'd100);
      apply_stimulus(1'b1, 10'd200, 1'b1, 2, 1'b0, '0);
      apply_stimulus(1'b1, 10'd103, 1'b0, 2, 1'b0, '0);
      check_output("flush_fill", int'(o_fill), 0);
      apply_stimulus(1'b1, 10'd104, 1'b0, 2, 1'b0, '0);
      apply_stimulus(1'b1, 10'd105, 1'b0, 2, 1'b1, 10'd103);
      drain("flush_drain", 2);

      // Over-range depth clamps to 64 and raises the sticky error.
      idle(2, 70);
      check_output("depth_err_set", int'(o_depth_err), 1);
      for (int k = 0; k < 70; k++)
         apply_stimulus(1'b1, 10'(k), 1'b0, 70, (k >= 64), 10'(k - 64));

      // Asynchronous reset between edges while outputs are flowing.
      #1;
      check_output("pre_reset_o_valid", int'(o_valid), 1);
      reset   = 1'b1;
      i_valid = 1'b0;
      sb_q.delete();
      #1;
      check_output("async_reset_o_valid", int'(o_valid), 0);
      check_output("async_reset_o_data", int'(o_data), 0);
      check_output("async_reset_o_fill", int'(o_fill), 0);
      check_output("async_reset_o_depth_err", int'(o_depth_err), 0);
      @(posedge clk);
      #3 reset = 1'b0;

      for (int k = 0; k < 70; k++)
         apply_stimulus(1'b1, 10'(300 + k), 1'b0, 70, (k >= 64), 10'(300 + k - 64));
      check_output("depth_err_after_reset", int'(o_depth_err), 1);
      drain("reset_drain", 70);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
